// File: rtl/dit_pkg.sv
// Shared definitions for the dit frame arbiter: input FSM encoding,
// channel tag width and complex-sample width helper.
package dit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM0 = 2'd1,
        STREAM1 = 2'd2
    } arb_state_t;

    localparam int unsigned CH_ID_W = 1;

    // Complex sample is {re,im}, each X_WDTH bits.
    function automatic int unsigned cplx_w(input int unsigned x_wdth);
        return 2 * x_wdth;
    endfunction

endpackage

// File: rtl/dit_tag_fifo.sv
// In-order FIFO of channel tags for frames granted but not yet fully output.
// Push and pop in the same cycle are accepted at any occupancy, including full.
module dit_tag_fifo
    import dit_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [CH_ID_W-1:0]    push_tag,
    input  logic                  pop,
    output logic [CH_ID_W-1:0]    head,
    output logic [DEPTH_LOG2:0]   count
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

    logic [CH_ID_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the head being popped this edge.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dit_frame_arbiter.sv
// Round-robin whole-frame arbiter feeding one dit FFT core from two sources,
// labelling each output frame with its source channel and overflow status.
module dit_frame_arbiter
    import dit_pkg::*;
#(
    parameter int unsigned N                 = 8,
    parameter int unsigned NLOG2             = 3,
    parameter int unsigned X_WDTH            = 32,
    parameter int unsigned MAX_INFLIGHT      = 4,
    parameter int unsigned MAX_INFLIGHT_LOG2 = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [cplx_w(X_WDTH)-1:0]     ch0_din,
    input  logic                          ch0_valid,
    output logic                          ch0_ready,
    input  logic [cplx_w(X_WDTH)-1:0]     ch1_din,
    input  logic                          ch1_valid,
    output logic                          ch1_ready,
    output logic [cplx_w(X_WDTH)-1:0]     fft_din,
    output logic                          fft_din_nd,
    input  logic [cplx_w(X_WDTH)-1:0]     fft_dout,
    input  logic                          fft_dout_nd,
    input  logic                          fft_overflow,
    output logic [cplx_w(X_WDTH)-1:0]     dout,
    output logic                          dout_nd,
    output logic                          dout_ch,
    output logic                          dout_first,
    output logic                          dout_last,
    output logic                          frame_overflow,
    output logic [MAX_INFLIGHT_LOG2:0]    inflight,
    output logic                          err_orphan
);

    localparam int unsigned                 LAST_I   = N - 1;
    localparam logic [NLOG2-1:0]            LAST_IDX = LAST_I[NLOG2-1:0];
    localparam logic [MAX_INFLIGHT_LOG2:0]  FULL_CNT = MAX_INFLIGHT[MAX_INFLIGHT_LOG2:0];

    arb_state_t                  state;
    arb_state_t                  state_nxt;
    logic [NLOG2-1:0]            in_count;
    logic [NLOG2-1:0]            out_count;
    logic                        last_grant;
    logic                        ovf_acc;
    logic                        hs;
    logic [cplx_w(X_WDTH)-1:0]   hs_din;
    logic                        tag_push;
    logic [CH_ID_W-1:0]          tag_push_ch;
    logic                        tag_pop;
    logic [CH_ID_W-1:0]          tag_head;
    logic [MAX_INFLIGHT_LOG2:0]  tag_count;
    logic                        out_last;

    dit_tag_fifo #(
        .DEPTH      (MAX_INFLIGHT),
        .DEPTH_LOG2 (MAX_INFLIGHT_LOG2)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tag_push),
        .push_tag (tag_push_ch),
        .pop      (tag_pop),
        .head     (tag_head),
        .count    (tag_count)
    );

    assign inflight = tag_count;

    always_comb begin
        state_nxt   = state;
        ch0_ready   = 1'b0;
        ch1_ready   = 1'b0;
        tag_push    = 1'b0;
        tag_push_ch = '0;
        hs          = 1'b0;
        hs_din      = '0;
        unique case (state)
            IDLE: begin
                if ((tag_count != FULL_CNT) && (ch0_valid || ch1_valid)) begin
                    tag_push = 1'b1;
                    // Both requesting: favour the channel not served last.
                    if (ch0_valid && ch1_valid) begin
                        tag_push_ch = ~last_grant;
                    end else begin
                        tag_push_ch = ch1_valid;
                    end
                    state_nxt = tag_push_ch[0] ? STREAM1 : STREAM0;
                end
            end
            STREAM0: begin
                ch0_ready = 1'b1;
                hs        = ch0_valid;
                hs_din    = ch0_din;
            end
            STREAM1: begin
                ch1_ready = 1'b1;
                hs        = ch1_valid;
                hs_din    = ch1_din;
            end
            default: state_nxt = IDLE;
        endcase
        if (hs && (in_count == LAST_IDX)) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_count   <= '0;
            last_grant <= 1'b1;
            fft_din    <= '0;
            fft_din_nd <= 1'b0;
        end else begin
            state      <= state_nxt;
            fft_din_nd <= hs;
            if (hs) begin
                fft_din  <= hs_din;
                in_count <= in_count + 1'b1;
                if (in_count == LAST_IDX) begin
                    last_grant <= (state == STREAM1);
                end
            end
        end
    end

    assign out_last = (out_count == LAST_IDX);
    assign tag_pop  = fft_dout_nd & out_last & (tag_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout           <= '0;
            dout_nd        <= 1'b0;
            dout_ch        <= 1'b0;
            dout_first     <= 1'b0;
            dout_last      <= 1'b0;
            frame_overflow <= 1'b0;
            out_count      <= '0;
            ovf_acc        <= 1'b0;
            err_orphan     <= 1'b0;
        end else begin
            dout           <= fft_dout;
            dout_nd        <= fft_dout_nd;
            dout_ch        <= tag_head[0];
            dout_first     <= fft_dout_nd & (out_count == '0);
            dout_last      <= fft_dout_nd & out_last;
            frame_overflow <= fft_dout_nd & out_last & (ovf_acc | fft_overflow);
            if (fft_dout_nd) begin
                out_count <= out_count + 1'b1;
                ovf_acc   <= out_last ? 1'b0 : (ovf_acc | fft_overflow);
                if (tag_count == '0) begin
                    err_orphan <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dit_frame_arbiter.sv
// Self-checking bench: loopback dit model plus a frame-level reference model
// compared against every DUT output on each falling clock edge.
module tb_dit_frame_arbiter;

    localparam int N   = 8;
    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] ch0_din = '0, ch1_din = '0;
    logic        ch0_valid = 1'b0, ch1_valid = 1'b0;
    logic        ch0_ready, ch1_ready;
    logic [63:0] fft_din;
    logic        fft_din_nd;
    logic [63:0] fft_dout = '0;
    logic        fft_dout_nd = 1'b0, fft_overflow = 1'b0;
    logic [63:0] dout;
    logic        dout_nd, dout_ch, dout_first, dout_last, frame_overflow, err_orphan;
    logic [2:0]  inflight;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dit_frame_arbiter #(
        .N(8), .NLOG2(3), .X_WDTH(32), .MAX_INFLIGHT(4), .MAX_INFLIGHT_LOG2(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_din(ch0_din), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
        .ch1_din(ch1_din), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
        .fft_din(fft_din), .fft_din_nd(fft_din_nd),
        .fft_dout(fft_dout), .fft_dout_nd(fft_dout_nd), .fft_overflow(fft_overflow),
        .dout(dout), .dout_nd(dout_nd), .dout_ch(dout_ch),
        .dout_first(dout_first), .dout_last(dout_last),
        .frame_overflow(frame_overflow), .inflight(inflight), .err_orphan(err_orphan)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        ch0_din = {$urandom, $urandom};
        ch1_din = {$urandom, $urandom};
    end

    // Loopback core: every accepted input sample reappears LAT cycles later.
    typedef struct { logic [63:0] d; int stamp; } cap_t;
    cap_t dq[$];
    cap_t cap;
    int   cyc = 0, emitted = 0, emit_budget = -1, ovf_at = -1;
    bit   dit_run = 1'b1, ovf_rand = 1'b0, inj = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq.delete();
            emitted = 0;
            fft_dout_nd = 1'b0;
            fft_dout = '0;
            fft_overflow = 1'b0;
        end else begin
            cyc++;
            if (fft_din_nd) dq.push_back('{fft_din, cyc});
            fft_dout_nd = 1'b0;
            fft_overflow = 1'b0;
            if (inj) begin
                inj = 1'b0;
                fft_dout_nd = 1'b1;
                fft_dout = {$urandom, $urandom};
            end else if (dit_run && dq.size() > 0 && emit_budget != 0 && cyc - dq[0].stamp >= LAT) begin
                cap = dq.pop_front();
                fft_dout_nd = 1'b1;
                fft_dout = cap.d;
                fft_overflow = (emitted == ovf_at) || (ovf_rand && $urandom_range(15) == 0);
                emitted++;
                if (emit_budget > 0) emit_budget--;
            end
        end
    end

    // Reference model: frame-level arbitration and output labelling rules.
    int          m_cur, m_cnt, m_pos, pre_n;
    int          m_tags[$];
    bit          m_last, m_ovf, do_pop;
    logic [63:0] e_fft_din, e_dout;
    bit          e_fft_nd, e_dout_nd, e_ch, e_first, e_last, e_fovf, e_orphan;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur = -1; m_cnt = 0; m_pos = 0; m_last = 1'b1; m_ovf = 1'b0;
            m_tags.delete();
            e_fft_din = '0; e_fft_nd = 0; e_dout = '0; e_dout_nd = 0;
            e_ch = 0; e_first = 0; e_last = 0; e_fovf = 0; e_orphan = 0;
        end else begin
            pre_n     = m_tags.size();
            e_dout    = fft_dout;
            e_dout_nd = fft_dout_nd;
            e_ch      = (pre_n > 0) && (m_tags[0] == 1);
            e_first   = fft_dout_nd && (m_pos == 0);
            e_last    = fft_dout_nd && (m_pos == N - 1);
            e_fovf    = e_last && (m_ovf || fft_overflow);
            do_pop    = e_last && (pre_n > 0);
            if (fft_dout_nd) begin
                if (pre_n == 0) e_orphan = 1;
                m_ovf = e_last ? 1'b0 : (m_ovf | fft_overflow);
                m_pos = (m_pos + 1) % N;
            end
            e_fft_nd = 0;
            if (m_cur < 0) begin
                if (pre_n < 4 && (ch0_valid || ch1_valid)) begin
                    if (ch0_valid && ch1_valid) m_cur = m_last ? 0 : 1;
                    else m_cur = ch1_valid ? 1 : 0;
                    m_tags.push_back(m_cur);
                end
            end else if ((m_cur == 0 && ch0_valid) || (m_cur == 1 && ch1_valid)) begin
                e_fft_nd = 1;
                e_fft_din = (m_cur == 0) ? ch0_din : ch1_din;
                m_cnt++;
                if (m_cnt == N) begin
                    m_cnt = 0;
                    m_last = (m_cur == 1);
                    m_cur = -1;
                end
            end
            if (do_pop) void'(m_tags.pop_front());
        end
    end

    bit chk_en = 1'b0;
    bit prev_r0 = 1'b0, prev_r1 = 1'b0;
    int obs_grants[$], obs_tags[$], obs_fovf[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("ch0_ready", ch0_ready, m_cur == 0);
            check("ch1_ready", ch1_ready, m_cur == 1);
            check("fft_din_nd", fft_din_nd, e_fft_nd);
            check("fft_din", fft_din, e_fft_din);
            check("dout", dout, e_dout);
            check("dout_nd", dout_nd, e_dout_nd);
            check("dout_ch", dout_ch, e_ch);
            check("dout_first", dout_first, e_first);
            check("dout_last", dout_last, e_last);
            check("frame_overflow", frame_overflow, e_fovf);
            check("inflight", inflight, m_tags.size());
            check("err_orphan", err_orphan, e_orphan);
        end
        if (ch0_ready && !prev_r0) obs_grants.push_back(0);
        if (ch1_ready && !prev_r1) obs_grants.push_back(1);
        if (dout_nd && dout_first) obs_tags.push_back(int'(dout_ch));
        if (dout_nd && dout_last) obs_fovf.push_back(int'(frame_overflow));
        prev_r0 = ch0_ready;
        prev_r1 = ch1_ready;
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic stream(input bit use0, input bit use1, input int nsamp, input string tag);
        int n = 0;
        int t = 0;
        ch0_valid = use0;
        ch1_valid = use1;
        while (n < nsamp && t < 40 * nsamp + 100) begin
            @(negedge clk);
            t++;
            if (fft_din_nd) n++;
        end
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        check({tag, "_samples"}, n, nsamp);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        dit_run = 1'b1;
        emit_budget = -1;
        while ((inflight != 0 || dq.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_drain"}, inflight, 0);
    endtask

    initial begin
        int n;
        int t;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_inflight", inflight, 0);
        check("rst_dout_nd", dout_nd, 0);
        check("rst_ready0", ch0_ready, 0);
        #2 rst_n = 1'b1;

        // Single frame on channel 0
        obs_tags.delete();
        stream(1, 0, 8, "single");
        drain("single");
        check("single_nframes", obs_tags.size(), 1);
        if (obs_tags.size() > 0) check("single_tag", obs_tags[0], 0);

        // Contention: both channels requesting for six frames
        do_reset();
        obs_grants.delete();
        obs_tags.delete();
        stream(1, 1, 48, "cont");
        drain("cont");
        check("cont_ngrants", obs_grants.size(), 6);
        check("cont_ntags", obs_tags.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs_grants.size()) check("cont_grant", obs_grants[i], i % 2);
            if (i < obs_tags.size()) check("cont_tag", obs_tags[i], i % 2);
        end

        // Mid-frame gap on channel 1
        obs_grants.delete();
        n = 0;
        t = 0;
        ch1_valid = 1'b1;
        while (n < 4 && t < 100) begin
            @(negedge clk);
            t++;
            if (fft_din_nd) n++;
        end
        check("gap_first4", n, 4);
        ch1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gap_nd", fft_din_nd, 0);
            check("gap_hold", ch1_ready, 1);
        end
        stream(0, 1, 4, "gap_rest");
        drain("gap");
        check("gap_ngrants", obs_grants.size(), 1);

        // Tag FIFO fills while the core is stalled
        do_reset();
        dit_run = 1'b0;
        obs_grants.delete();
        ch0_valid = 1'b1;
        ch1_valid = 1'b1;
        repeat (60) @(negedge clk);
        check("full_grants", obs_grants.size(), 4);
        check("full_inflight", inflight, 4);
        check("full_ready0", ch0_ready, 0);
        check("full_ready1", ch1_ready, 0);
        emit_budget = 8;
        dit_run = 1'b1;
        repeat (40) @(negedge clk);
        check("full_grants_after", obs_grants.size(), 5);
        check("full_inflight_after", inflight, 4);
        check("full_ready_after", {ch0_ready, ch1_ready}, 0);
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        drain("full");

        // Overflow on output sample 3 of frame 2
        do_reset();
        ovf_at = 10;
        obs_fovf.delete();
        for (int f = 0; f < 3; f++) stream(1, 0, 8, "ovf");
        drain("ovf");
        ovf_at = -1;
        check("ovf_nframes", obs_fovf.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < obs_fovf.size()) check("ovf_flag", obs_fovf[i], i == 1);

        // Reset in the middle of an input frame
        n = 0;
        t = 0;
        ch0_valid = 1'b1;
        while (n < 5 && t < 100) begin
            @(negedge clk);
            t++;
            if (fft_din_nd) n++;
        end
        #2 rst_n = 1'b0;
        ch0_valid = 1'b0;
        #1;
        check("mrst_ready0", ch0_ready, 0);
        check("mrst_din_nd", fft_din_nd, 0);
        check("mrst_din", fft_din, 0);
        check("mrst_inflight", inflight, 0);
        check("mrst_dout", dout, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        obs_grants.delete();
        obs_tags.delete();
        stream(1, 0, 8, "mrst");
        drain("mrst");
        check("mrst_ngrants", obs_grants.size(), 1);
        if (obs_tags.size() == 1) check("mrst_tag", obs_tags[0], 0);
        else check("mrst_ntags", obs_tags.size(), 1);

        // Orphan output with nothing in flight
        inj = 1'b1;
        repeat (3) @(negedge clk);
        check("orphan_set", err_orphan, 1);
        repeat (20) @(negedge clk);
        check("orphan_held", err_orphan, 1);
        do_reset();
        @(negedge clk);
        check("orphan_clr", err_orphan, 0);

        // Randomized traffic with core stalls and overflow pulses
        do_reset();
        ovf_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            ch0_valid = ($urandom_range(3) != 0);
            ch1_valid = ($urandom_range(3) != 0);
            dit_run   = ($urandom_range(7) != 0);
        end
        dit_run = 1'b1;
        ch0_valid = 1'b1;
        ch1_valid = 1'b1;
        t = 0;
        while ((ch0_ready || ch1_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        check("rand_settle", ch0_ready | ch1_ready, 0);
        drain("rand");
        ovf_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dit_frame_arbiter.md
Name: dit_frame_arbiter

Overview:
- Shares one dit FFT core between two sample sources, channel 0 and channel 1.
- Grants whole N-sample frames round-robin and streams the granted frame into the core's din/din_nd port.
- Keeps an in-order FIFO of channel tags so that each FFT output frame is labelled with its source, first/last markers and a per-frame overflow flag.
- Sits between the front-end sample sources and the dit instance; rst_n is shared with the dit.

Parameters:
- N, 8, FFT length in samples; power of two.
- NLOG2, 3, log2(N).
- X_WDTH, 32, width of each real/imag component; complex sample is 2*X_WDTH.
- MAX_INFLIGHT, 4, tag FIFO depth, i.e. the maximum number of frames granted but not yet fully output.
- MAX_INFLIGHT_LOG2, 2, log2(MAX_INFLIGHT).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ch0_din  in  2*X_WDTH  channel 0 sample, {re,im}.
- ch0_valid  in  1  channel 0 sample valid.
- ch0_ready  out  1  channel 0 sample accepted this cycle when valid&ready.
- ch1_din, ch1_valid, ch1_ready  as for channel 0.
- fft_din  out  2*X_WDTH  sample to dit din.
- fft_din_nd  out  1  to dit din_nd.
- fft_dout  in  2*X_WDTH  from dit dout.
- fft_dout_nd  in  1  from dit dout_nd.
- fft_overflow  in  1  from dit overflow.
- dout  out  2*X_WDTH  registered FFT output sample.
- dout_nd  out  1  dout valid.
- dout_ch  out  1  source channel of the current output frame.
- dout_first  out  1  first sample of an output frame.
- dout_last  out  1  last sample of an output frame.
- frame_overflow  out  1  valid with dout_last: the core flagged overflow during this frame.
- inflight  out  MAX_INFLIGHT_LOG2+1  tag FIFO occupancy.
- err_orphan  out  1  sticky: output arrived with no tag queued.

Behaviour:
- Reset (async, rst_n=0): every output is 0; state is IDLE; last_grant is 1, so channel 0 wins first; in_count=0, out_count=0; tag FIFO empty; overflow accumulator and err_orphan are cleared.
- Input FSM has three states: IDLE, STREAM0, STREAM1.
- IDLE:
  - chX_ready=0.
  - If inflight==MAX_INFLIGHT, stay in IDLE.
  - Otherwise pick among the channels with valid=1, giving priority to the channel other than last_grant.
  - Move to STREAMx next cycle and push tag x into the FIFO on that same edge.
- STREAMx:
  - chx_ready=1; the other channel's ready=0.
  - On each valid&ready handshake, fft_din<=chx_din and fft_din_nd<=1 at the next edge; otherwise fft_din_nd<=0. Input latency is 1 cycle.
  - Gaps are allowed mid-frame; the frame is never preempted.
  - On the handshake with in_count==N-1: in_count<=0, last_grant<=x, go to IDLE.
  - The next grant therefore has at least one idle cycle between frames.
- Output path (registered, 1-cycle latency):
  - dout<=fft_dout and dout_nd<=fft_dout_nd.
  - dout_ch<=tag at FIFO head.
  - dout_first<=(out_count==0)&fft_dout_nd.
  - dout_last<=(out_count==N-1)&fft_dout_nd.
  - out_count increments on every fft_dout_nd and wraps to 0 after N-1.
- Overflow: ovf_acc ORs fft_overflow on every fft_dout_nd cycle of the frame.
  - frame_overflow<=ovf_acc|fft_overflow on the last-sample cycle, otherwise 0.
  - ovf_acc clears after the last sample.
- Tag pop happens on the last output sample.
  - A push and a pop in the same cycle are legal at any occupancy, including full; occupancy is then unchanged.
- fft_dout_nd with the FIFO empty: set err_orphan (sticky until reset), drive dout_ch=0, and do not pop.
- Reset mid-frame: all partial input and output frames are discarded; the dit is reset by the same rst_n.
- Counters are NLOG2 bits wide and wrap naturally.

Decomposition:
- Shared package dit_pkg holds:
  - the FSM state encoding (IDLE=2'd0, STREAM0=2'd1, STREAM1=2'd2);
  - the channel-id width (1);
  - the complex-sample width macro, 2*X_WDTH.
- Sub-module dit_tag_fifo is a synchronous FIFO: depth MAX_INFLIGHT, width 1, with push, pop, head, count, and async active-low reset.
- The FSM, counters and output registers stay in dit_frame_arbiter.

Test Plan:
- Single frame: ch0_valid held for samples 1..8, ch1 idle, loopback dit model with latency 10.
  - Required: fft_din_nd high for 8 cycles starting 1 cycle after the first handshake.
  - Required: dout_ch=0, dout_first on sample 1, dout_last on sample 8, inflight returns 0.
- Contention: both valid continuously from reset for 3 frames each.
  - Required grant order 0,1,0,1,0,1.
  - Required: no other-channel ready during a frame; output tags follow the same order.
- Mid-frame gaps: ch1 drops valid for 3 cycles after sample 4.
  - Required: fft_din_nd low for those 3 cycles, no grant switch, frame completes with 8 samples.
- FIFO full: stalled dit model (no outputs), both channels valid.
  - Required: exactly 4 frames granted, then ready stays 0 and inflight=4.
  - Required: after the dit emits one frame, exactly one more grant follows.
- Overflow: fft_overflow pulses on output sample 3 of frame 2 only.
  - Required: frame_overflow=1 with frame 2's dout_last and 0 for frames 1 and 3.
- Reset mid-frame: assert rst_n=0 after 5 input samples.
  - Required: all outputs 0 and inflight=0.
  - Required: after release, a fresh frame goes to ch0 and completes with correct first/last.
- Orphan: inject fft_dout_nd with inflight=0.
  - Required: err_orphan=1 and held until reset.
